gpio_debounce: RTL and testbench

Per-pin input conditioning stage that sits directly upstream of the GPIO peripheral's `gpio_in` port. It synchronizes raw pad inputs, then applies a counter-based debounce filter that is timed by a shared prescaler. The peripheral then sees only glitch-free levels. Each pin can be bypassed individually. An optional edge-event output gives registered rise/fall pulses.

---
 rtl/gpio_debounce_pkg.sv | 11 +
 rtl/gpio_debounce_cell.sv | 86 ++++++++
 rtl/gpio_debounce.sv | 60 ++++++
 tb/tb_gpio_debounce.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_debounce_pkg.sv
// Shared constants and types for the gpio_debounce input-conditioning block.
// Edge-event outputs are enabled by defining GPIO_DEBOUNCE_EDGE_EVT_EN.
package gpio_debounce_pkg;

    localparam int DefaultCntWidth   = 8;
    localparam int DefaultPrescWidth = 16;

    // Per-pin debounce counter at the default width.
    typedef logic [DefaultCntWidth-1:0] cnt_t;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin: synchronizer chain, debounce counter, filtered level and edge events.
// Edge registers exist only when GPIO_DEBOUNCE_EDGE_EVT_EN is defined.
module gpio_debounce_cell
    import gpio_debounce_pkg::*;
#(
    parameter int SyncStages = 2,
    parameter int CntWidth   = DefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic [CntWidth-1:0] threshold_i,
    input  logic                bypass_i,
    input  logic                raw_i,
    output logic                filt_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  sync;
    logic                  filt_q, filt_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw_i};
        end
    end

    assign sync = sync_q[SyncStages-1];

    // A sync level equal to filt clears the count, so any bounce restarts qualification.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (bypass_i) begin
            filt_d = sync;
            cnt_d  = '0;
        end else if (sync == filt_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q >= threshold_i) begin
                filt_d = sync;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

`ifdef GPIO_DEBOUNCE_EDGE_EVT_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= filt_d & ~filt_q;
            fall_q <= ~filt_d & filt_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioning: per-pin synchronize + debounce with a shared prescaler.
// Optional rise/fall pulses when GPIO_DEBOUNCE_EDGE_EVT_EN is defined; otherwise tied to 0.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int NrGPIOs    = 64,
    parameter int SyncStages = 2,
    parameter int CntWidth   = DefaultCntWidth,
    parameter int PrescWidth = DefaultPrescWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [PrescWidth-1:0] prescale_i,
    input  logic [CntWidth-1:0]   threshold_i,
    input  logic [NrGPIOs-1:0]    bypass_i,
    input  logic [NrGPIOs-1:0]    gpio_raw_i,
    output logic [NrGPIOs-1:0]    gpio_filt_o,
    output logic [NrGPIOs-1:0]    gpio_rise_o,
    output logic [NrGPIOs-1:0]    gpio_fall_o
);

    logic [PrescWidth-1:0] pcnt_q, pcnt_d;
    logic                  tick;

    // >= rather than == so lowering prescale_i mid-count cannot strand the counter.
    assign tick = (pcnt_q >= prescale_i);

    always_comb begin
        pcnt_d = pcnt_q + PrescWidth'(1);
        if (tick) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    for (genvar i = 0; i < NrGPIOs; i++) begin : g_pin
        gpio_debounce_cell #(
            .SyncStages (SyncStages),
            .CntWidth   (CntWidth)
        ) u_cell (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .tick_i      (tick),
            .threshold_i (threshold_i),
            .bypass_i    (bypass_i[i]),
            .raw_i       (gpio_raw_i[i]),
            .filt_o      (gpio_filt_o[i]),
            .rise_o      (gpio_rise_o[i]),
            .fall_o      (gpio_fall_o[i])
        );
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce: latency scoreboard plus per-scenario checks.
module tb_gpio_debounce;

    localparam int N  = 8;
    localparam int PW = 16;
    localparam int CW = 8;
`ifdef GPIO_DEBOUNCE_EDGE_EVT_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [CW-1:0] threshold = '0;
    logic [N-1:0]  bypass = '0;
    logic [N-1:0]  raw = '0;
    logic [N-1:0]  filt, rise, fall;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    gpio_debounce #(
        .NrGPIOs    (N),
        .SyncStages (2),
        .CntWidth   (CW),
        .PrescWidth (PW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .prescale_i  (prescale),
        .threshold_i (threshold),
        .bypass_i    (bypass),
        .gpio_raw_i  (raw),
        .gpio_filt_o (filt),
        .gpio_rise_o (rise),
        .gpio_fall_o (fall)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // driver tasks: all drive and sample happens 1 time unit after the rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        raw    = '0;
        bypass = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_change(input int pin, input int limit, output int lat,
                               output logic r, output logic f);
        logic start;
        bit   done;
        start = filt[pin];
        lat   = -1;
        r     = 1'b0;
        f     = 1'b0;
        done  = 1'b0;
        for (int n = 1; n <= limit && !done; n++) begin
            step(1);
            if (filt[pin] !== start) begin
                lat  = n;
                r    = rise[pin];
                f    = fall[pin];
                done = 1'b1;
            end
        end
    endtask

    task automatic sb_check(input string name, input int lat);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (lat !== int'(exp)) begin
            errors++;
            $display("FAIL %s: latency got %0d expected %0d", name, lat, int'(exp));
        end
    endtask

    task automatic test_reset();
        int lat; logic r, f;
        prescale = 0; threshold = 3;
        do_reset();
        raw = '1;
        rst_n = 1'b0;
        step(3);
        checks++;
        if (filt !== '0 || rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL reset_outputs: filt=%h rise=%h fall=%h expected 0", filt, rise, fall);
        end
        rst_n = 1'b1;
        exp_q.push_back(32'd6);
        wait_change(0, 20, lat, r, f);
        sb_check("reset_held_high_latency", lat);
        checks++;
        if (filt !== '1 || rise !== {N{EdgeEn}}) begin
            errors++;
            $display("FAIL reset_all_pins: filt=%h rise=%h expected %h / %h", filt, rise, {N{1'b1}}, {N{EdgeEn}});
        end
    endtask

    task automatic test_stable_no_prescale();
        int lat; logic r, f;
        prescale = 0; threshold = 3;
        do_reset();
        raw[0] = 1'b1;
        exp_q.push_back(32'd6);
        wait_change(0, 20, lat, r, f);
        sb_check("stable_rise_latency", lat);
        checks++;
        if (r !== EdgeEn || f !== 1'b0) begin
            errors++;
            $display("FAIL stable_rise_pulse: rise=%b fall=%b expected %b 0", r, f, EdgeEn);
        end
        step(1);
        checks++;
        if (rise[0] !== 1'b0 || filt[0] !== 1'b1) begin
            errors++;
            $display("FAIL stable_rise_one_cycle: rise=%b filt=%b expected 0 1", rise[0], filt[0]);
        end
        raw[0] = 1'b0;
        exp_q.push_back(32'd6);
        wait_change(0, 20, lat, r, f);
        sb_check("stable_fall_latency", lat);
        checks++;
        if (f !== EdgeEn || r !== 1'b0) begin
            errors++;
            $display("FAIL stable_fall_pulse: fall=%b rise=%b expected %b 0", f, r, EdgeEn);
        end
    endtask

    task automatic test_glitch();
        int first_hi;
        int pulses;
        prescale = 0; threshold = 3;
        do_reset();
        raw[1] = 1'b1;
        first_hi = -1;
        pulses = 0;
        for (int n = 1; n <= 15; n++) begin
            step(1);
            if (n == 3) raw[1] = 1'b0;
            if (filt[1] === 1'b1 && first_hi < 0) first_hi = n;
            if (rise[1] === 1'b1) pulses++;
        end
        checks++;
        if (first_hi != -1 || pulses != 0) begin
            errors++;
            $display("FAIL glitch_3_rejected: filt rose at %0d with %0d pulses, expected never", first_hi, pulses);
        end
        raw[1] = 1'b1;
        first_hi = -1;
        exp_q.push_back(32'd6);
        for (int n = 1; n <= 15; n++) begin
            step(1);
            if (n == 4) raw[1] = 1'b0;
            if (filt[1] === 1'b1 && first_hi < 0) first_hi = n;
        end
        sb_check("glitch_4_passes", first_hi);
    endtask

    task automatic test_prescaled();
        int lat; logic r, f;
        prescale = 9; threshold = 1;
        do_reset();
        step($urandom_range(0, 9));
        raw[3] = 1'b1;
        wait_change(3, 40, lat, r, f);
        checks++;
        if (lat < 13 || lat > 22) begin
            errors++;
            $display("FAIL prescaled_window: latency got %0d expected 13..22", lat);
        end
        do_reset();
        step($urandom_range(0, 9));
        raw[3] = 1'b1;
        step(5);
        raw[3] = 1'b0;
        step(1);
        raw[3] = 1'b1;
        checks++;
        if (filt[3] !== 1'b0) begin
            errors++;
            $display("FAIL prescaled_early: filt=%b expected 0 during bounce", filt[3]);
        end
        wait_change(3, 40, lat, r, f);
        checks++;
        if (lat < 13 || lat > 22) begin
            errors++;
            $display("FAIL prescaled_bounce_requal: latency after bounce got %0d expected 13..22", lat);
        end
    endtask

    task automatic test_bypass();
        int lat; logic r, f;
        prescale = 100; threshold = 255;
        do_reset();
        bypass = 8'h03;
        raw[2:0] = 3'b111;
        exp_q.push_back(32'd3);
        wait_change(0, 10, lat, r, f);
        sb_check("bypass_rise_latency", lat);
        checks++;
        if (filt[2:0] !== 3'b011 || rise[2:0] !== {1'b0, EdgeEn, EdgeEn}) begin
            errors++;
            $display("FAIL bypass_rise: filt=%b rise=%b expected 011 0%b%b", filt[2:0], rise[2:0], EdgeEn, EdgeEn);
        end
        raw[0] = 1'b0;
        exp_q.push_back(32'd3);
        wait_change(0, 10, lat, r, f);
        sb_check("bypass_fall_latency", lat);
        checks++;
        if (filt[2:0] !== 3'b010 || f !== EdgeEn) begin
            errors++;
            $display("FAIL bypass_fall: filt=%b fall=%b expected 010 %b", filt[2:0], f, EdgeEn);
        end
        step(1);
        checks++;
        if (rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL bypass_pulse_width: rise=%h fall=%h expected 0", rise, fall);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic r, f;
        int pulses;
        prescale = 0; threshold = 10;
        do_reset();
        raw[5] = 1'b1;
        step(16);
        raw[4] = 1'b1;
        step(7);
        rst_n = 1'b0;
        step(1);
        checks++;
        if (filt !== '0 || rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: filt=%h rise=%h fall=%h expected 0", filt, rise, fall);
        end
        rst_n = 1'b1;
        exp_q.push_back(32'd13);
        wait_change(4, 30, lat, r, f);
        sb_check("reset_mid_requal", lat);
        pulses = int'(r);
        for (int n = 0; n < 5; n++) begin
            step(1);
            pulses += int'(rise[4]);
        end
        checks++;
        if (pulses != int'(EdgeEn) || filt[5:4] !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_single_pulse: pulses=%0d filt=%b expected %0d 11", pulses, filt[5:4], EdgeEn);
        end
    endtask

    task automatic test_threshold_lower();
        int lat; logic r, f;
        prescale = 0; threshold = 200;
        do_reset();
        raw[6] = 1'b1;
        step(54);
        checks++;
        if (filt[6] !== 1'b0) begin
            errors++;
            $display("FAIL thr_hold: filt=%b expected 0 while counting", filt[6]);
        end
        threshold = 10;
        exp_q.push_back(32'd1);
        wait_change(6, 10, lat, r, f);
        sb_check("thr_lowered_next_tick", lat);
    endtask

    task automatic test_random_latency();
        int lat; logic r, f;
        int pin;
        int t;
        for (int it = 0; it < 4; it++) begin
            prescale = 0;
            t = $urandom_range(0, 7);
            pin = $urandom_range(0, N - 1);
            threshold = CW'(t);
            do_reset();
            raw[pin] = 1'b1;
            exp_q.push_back(32'(3 + t));
            wait_change(pin, 30, lat, r, f);
            sb_check("random_latency", lat);
            checks++;
            if (filt !== (N'(1) << pin)) begin
                errors++;
                $display("FAIL random_isolation: filt=%h expected %h", filt, N'(1) << pin);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stable_no_prescale();
        test_glitch();
        test_prescaled();
        test_bypass();
        test_reset_mid();
        test_threshold_lower();
        test_random_latency();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
